// File: rtl/nav_pkg.sv
// Shared types for the button navigation sequencer: FSM states and the
// cursor direction encoding used by the controller and its position counter.
package nav_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PRESS      = 3'd1,
        REPEAT     = 3'd2,
        ENTER_HOLD = 3'd3,
        WAIT_REL   = 3'd4
    } nav_state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Number of buttons currently asserted, used to detect chords.
    function automatic logic [1:0] count_active(input logic a, input logic b, input logic c);
        return {1'b0, a} + {1'b0, b} + {1'b0, c};
    endfunction

endpackage

// File: rtl/nav_pos_counter.sv
// Modulo-N_POS up/down cursor counter with synchronous clear; the wrap at
// both ends keeps the value inside 0..N_POS-1 even when N_POS is not a power of two.
module nav_pos_counter
    import nav_pkg::*;
#(
    parameter int N_POS = 8,
    parameter int POS_W = $clog2(N_POS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic             dir_i,
    output logic [POS_W-1:0] pos_o
);

    localparam logic [POS_W-1:0] POS_LAST = POS_W'(N_POS - 1);

    logic [POS_W-1:0] pos_q;
    logic [POS_W-1:0] pos_d;

    always_comb begin
        pos_d = pos_q;
        if (clear_i) begin
            pos_d = '0;
        end else if (step_i) begin
            if (dir_i == DIR_RIGHT) begin
                pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_q <= '0;
        end else begin
            pos_q <= pos_d;
        end
    end

    assign pos_o = pos_q;

endmodule

// File: rtl/btn_nav_controller.sv
// Turns debounced left/right/enter levels into cursor steps with auto-repeat,
// short-press selections and a long-press clear pulse. All outputs are registered.
module btn_nav_controller
    import nav_pkg::*;
#(
    parameter  int N_POS      = 8,
    parameter  int DELAY_CYC  = 25_000_000,
    parameter  int REPEAT_CYC = 5_000_000,
    parameter  int HOLD_CYC   = 100_000_000,
    parameter  int CNT_W      = 27,
    localparam int POS_W      = $clog2(N_POS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             left_lvl,
    input  logic             right_lvl,
    input  logic             enter_lvl,
    output logic [POS_W-1:0] pos,
    output logic             step_pulse,
    output logic             step_dir,
    output logic             select_pulse,
    output logic [POS_W-1:0] sel_pos,
    output logic             clear_pulse,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

    nav_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_dir_q, held_dir_d;
    logic             step_dir_q, step_dir_d;
    logic             step_pulse_q, step_pulse_d;
    logic             select_pulse_q, select_pulse_d;
    logic             clear_pulse_q, clear_pulse_d;
    logic             busy_q, busy_d;
    logic [POS_W-1:0] sel_pos_q, sel_pos_d;

    logic             step_en;
    logic             pos_clear;
    logic [1:0]       n_active;
    logic             held_lvl;
    logic             other_lvl;
    logic [CNT_W-1:0] cnt_last;

    assign n_active  = count_active(left_lvl, right_lvl, enter_lvl);
    assign held_lvl  = (held_dir_q == DIR_RIGHT) ? right_lvl : left_lvl;
    assign other_lvl = enter_lvl | ((held_dir_q == DIR_RIGHT) ? left_lvl : right_lvl);
    assign cnt_last  = (state_q == PRESS) ? DELAY_LAST : REPEAT_LAST;

    // Release and chord checks come before the repeat match so a button
    // released on the match edge never produces a late step.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        held_dir_d     = held_dir_q;
        step_dir_d     = step_dir_q;
        sel_pos_d      = sel_pos_q;
        step_en        = 1'b0;
        pos_clear      = 1'b0;
        select_pulse_d = 1'b0;
        clear_pulse_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (n_active >= 2'd2) begin
                    state_d = WAIT_REL;
                end else if (left_lvl || right_lvl) begin
                    held_dir_d = right_lvl ? DIR_RIGHT : DIR_LEFT;
                    step_en    = 1'b1;
                    step_dir_d = right_lvl ? DIR_RIGHT : DIR_LEFT;
                    cnt_d      = '0;
                    state_d    = PRESS;
                end else if (enter_lvl) begin
                    cnt_d   = '0;
                    state_d = ENTER_HOLD;
                end
            end
            PRESS, REPEAT: begin
                if (!held_lvl) begin
                    state_d = IDLE;
                end else if (other_lvl) begin
                    state_d = WAIT_REL;
                end else if (cnt_q == cnt_last) begin
                    step_en    = 1'b1;
                    step_dir_d = held_dir_q;
                    cnt_d      = '0;
                    state_d    = REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ENTER_HOLD: begin
                if (left_lvl || right_lvl) begin
                    state_d = WAIT_REL;
                end else if (!enter_lvl) begin
                    select_pulse_d = 1'b1;
                    sel_pos_d      = pos;
                    state_d        = IDLE;
                end else if (cnt_q == HOLD_LAST) begin
                    clear_pulse_d = 1'b1;
                    pos_clear     = 1'b1;
                    state_d       = WAIT_REL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_REL: begin
                if (n_active == 2'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        step_pulse_d = step_en;
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            held_dir_q     <= DIR_LEFT;
            step_dir_q     <= DIR_LEFT;
            step_pulse_q   <= 1'b0;
            select_pulse_q <= 1'b0;
            clear_pulse_q  <= 1'b0;
            busy_q         <= 1'b0;
            sel_pos_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            held_dir_q     <= held_dir_d;
            step_dir_q     <= step_dir_d;
            step_pulse_q   <= step_pulse_d;
            select_pulse_q <= select_pulse_d;
            clear_pulse_q  <= clear_pulse_d;
            busy_q         <= busy_d;
            sel_pos_q      <= sel_pos_d;
        end
    end

    nav_pos_counter #(
        .N_POS (N_POS),
        .POS_W (POS_W)
    ) u_pos (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (pos_clear),
        .step_i  (step_en),
        .dir_i   (step_dir_d),
        .pos_o   (pos)
    );

    assign step_pulse   = step_pulse_q;
    assign step_dir     = step_dir_q;
    assign select_pulse = select_pulse_q;
    assign sel_pos      = sel_pos_q;
    assign clear_pulse  = clear_pulse_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_btn_nav_controller.sv
// Self-checking bench for btn_nav_controller: directed scenarios plus random
// button traffic, all compared against a gesture-age reference model.
module tb_btn_nav_controller;

    localparam int N_POS      = 5;
    localparam int DELAY_CYC  = 4;
    localparam int REPEAT_CYC = 2;
    localparam int HOLD_CYC   = 6;
    localparam int CNT_W      = 4;
    localparam int POS_W      = $clog2(N_POS);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             left_lvl = 1'b0;
    logic             right_lvl = 1'b0;
    logic             enter_lvl = 1'b0;
    logic [POS_W-1:0] pos;
    logic             step_pulse;
    logic             step_dir;
    logic             select_pulse;
    logic [POS_W-1:0] sel_pos;
    logic             clear_pulse;
    logic             busy;

    int nVec = 0;
    int nMis = 0;

    // Reference model: gesture kind plus its age in edges since it began.
    localparam int G_NONE = 0, G_NAV = 1, G_ENTER = 2, G_BLOCKED = 3;
    int mGesture = G_NONE;
    int mAge     = 0;
    int mNavRight = 0;
    int mPos = 0, mSelPos = 0;
    int mStep = 0, mStepDir = 0, mSelect = 0, mClear = 0, mBusy = 0;

    always #5 clk = ~clk;

    btn_nav_controller #(
        .N_POS      (N_POS),
        .DELAY_CYC  (DELAY_CYC),
        .REPEAT_CYC (REPEAT_CYC),
        .HOLD_CYC   (HOLD_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .left_lvl     (left_lvl),
        .right_lvl    (right_lvl),
        .enter_lvl    (enter_lvl),
        .pos          (pos),
        .step_pulse   (step_pulse),
        .step_dir     (step_dir),
        .select_pulse (select_pulse),
        .sel_pos      (sel_pos),
        .clear_pulse  (clear_pulse),
        .busy         (busy)
    );

    task automatic modelStep(input int goRight);
        mStep    = 1;
        mStepDir = goRight;
        mPos     = goRight ? (mPos + 1) % N_POS : (mPos + N_POS - 1) % N_POS;
    endtask

    task automatic modelEdge(input logic l, input logic r, input logic e, input logic rn);
        int heldNow, otherNow, nAct;
        mStep = 0; mSelect = 0; mClear = 0;
        nAct = int'(l) + int'(r) + int'(e);
        if (!rn) begin
            mGesture = G_NONE; mAge = 0; mPos = 0; mSelPos = 0; mStepDir = 0;
        end else begin
            case (mGesture)
                G_NONE: begin
                    if (nAct >= 2) mGesture = G_BLOCKED;
                    else if (l || r) begin
                        mGesture = G_NAV; mAge = 0; mNavRight = int'(r);
                        modelStep(mNavRight);
                    end else if (e) begin
                        mGesture = G_ENTER; mAge = 0;
                    end
                end
                G_NAV: begin
                    mAge++;
                    heldNow  = mNavRight ? int'(r) : int'(l);
                    otherNow = int'(e) | (mNavRight ? int'(l) : int'(r));
                    if (heldNow == 0) mGesture = G_NONE;
                    else if (otherNow != 0) mGesture = G_BLOCKED;
                    else if (mAge >= DELAY_CYC && ((mAge - DELAY_CYC) % REPEAT_CYC) == 0)
                        modelStep(mNavRight);
                end
                G_ENTER: begin
                    mAge++;
                    if (l || r) mGesture = G_BLOCKED;
                    else if (!e) begin
                        mSelect = 1; mSelPos = mPos; mGesture = G_NONE;
                    end else if (mAge == HOLD_CYC) begin
                        mClear = 1; mPos = 0; mGesture = G_BLOCKED;
                    end
                end
                default: if (nAct == 0) mGesture = G_NONE;
            endcase
        end
        mBusy = (mGesture != G_NONE) ? 1 : 0;
    endtask

    // Drive one set of levels across a rising edge, advance the model, and
    // leave time 1 unit after the edge for sampling.
    task automatic tick(input logic l, input logic r, input logic e, input logic rn);
        left_lvl = l; right_lvl = r; enter_lvl = e; rst_n = rn;
        @(posedge clk);
        modelEdge(l, r, e, rn);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        nVec++;
        if ({pos, step_pulse, step_dir, select_pulse, sel_pos, clear_pulse, busy} !== '0) begin
            nMis++;
            $display("[TB] FAIL reset_outputs got pos=%0d step=%0b dir=%0b sel=%0b selpos=%0d clr=%0b busy=%0b want all 0",
                     pos, step_pulse, step_dir, select_pulse, sel_pos, clear_pulse, busy);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_single_step();
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        nVec++;
        if (pos !== 3'd1 || step_pulse !== 1'b1 || step_dir !== 1'b1 || busy !== 1'b1) begin
            nMis++;
            $display("[TB] FAIL single_step got pos=%0d step=%0b dir=%0b busy=%0b want 1 1 1 1", pos, step_pulse, step_dir, busy);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        nVec++;
        if (step_pulse !== 1'b0 || busy !== 1'b0 || int'(pos) != mPos) begin
            nMis++;
            $display("[TB] FAIL single_release got step=%0b busy=%0b pos=%0d want 0 0 %0d", step_pulse, busy, pos, mPos);
        end
    endtask

    task automatic test_wrap();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        nVec++;
        if (pos !== 3'd4 || step_dir !== 1'b0) begin
            nMis++;
            $display("[TB] FAIL wrap_left got pos=%0d dir=%0b want 4 0", pos, step_dir);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        nVec++;
        if (pos !== 3'd0 || step_dir !== 1'b1) begin
            nMis++;
            $display("[TB] FAIL wrap_right got pos=%0d dir=%0b want 0 1", pos, step_dir);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_auto_repeat();
        int nSteps = 0;
        logic expStep;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            expStep = (i == 0 || i == 4 || i == 6 || i == 8);
            nVec++;
            if (step_pulse !== expStep || int'(step_pulse) != mStep) begin
                nMis++;
                $display("[TB] FAIL repeat_step[%0d] got %0b want %0b", i, step_pulse, expStep);
            end
            if (step_pulse === 1'b1) nSteps++;
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        nVec++;
        if (step_pulse !== 1'b0 || pos !== 3'd4 || nSteps != 4) begin
            nMis++;
            $display("[TB] FAIL repeat_end got step=%0b pos=%0d steps=%0d want 0 4 4", step_pulse, pos, nSteps);
        end
    endtask

    task automatic test_enter();
        int nSel = 0;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b1, 1'b0, 1'b1);
            tick(1'b0, 1'b0, 1'b0, 1'b1);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            if (select_pulse === 1'b1) nSel++;
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        nVec++;
        if (select_pulse !== 1'b1 || sel_pos !== 3'd2 || pos !== 3'd2 || nSel != 0) begin
            nMis++;
            $display("[TB] FAIL short_enter got sel=%0b selpos=%0d pos=%0d early=%0d want 1 2 2 0", select_pulse, sel_pos, pos, nSel);
        end
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, 1'b0, 1'b1, 1'b1);
            nVec++;
            if (clear_pulse !== (i == 6) || int'(clear_pulse) != mClear || int'(pos) != mPos) begin
                nMis++;
                $display("[TB] FAIL long_enter[%0d] got clr=%0b pos=%0d want %0b %0d", i, clear_pulse, pos, (i == 6), mPos);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        nVec++;
        if (select_pulse !== 1'b0 || pos !== 3'd0) begin
            nMis++;
            $display("[TB] FAIL long_release got sel=%0b pos=%0d want 0 0", select_pulse, pos);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_chords();
        int nBad = 0;
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        if (step_pulse === 1'b1) nBad++;
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        if (step_pulse === 1'b1 || busy !== 1'b1) nBad++;
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        nVec++;
        if (nBad != 0 || busy !== 1'b0 || int'(pos) != mPos) begin
            nMis++;
            $display("[TB] FAIL chord_lr got bad=%0d busy=%0b pos=%0d want 0 0 %0d", nBad, busy, pos, mPos);
        end
        nBad = 0;
        tick(1'b0, 1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            tick(1'b0, (i < 4), 1'b1, 1'b1);
            if (select_pulse === 1'b1 || clear_pulse === 1'b1 || step_pulse === 1'b1) nBad++;
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        if (select_pulse === 1'b1) nBad++;
        nVec++;
        if (nBad != 0 || busy !== 1'b0) begin
            nMis++;
            $display("[TB] FAIL chord_enter got bad=%0d busy=%0b want 0 0", nBad, busy);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        nVec++;
        if ({pos, step_pulse, step_dir, select_pulse, sel_pos, clear_pulse, busy} !== '0) begin
            nMis++;
            $display("[TB] FAIL reset_mid got pos=%0d step=%0b dir=%0b busy=%0b want all 0", pos, step_pulse, step_dir, busy);
        end
        tick(1'b0, 1'b1, 1'b0, 1'b1);
        nVec++;
        if (step_pulse !== 1'b1 || pos !== 3'd1 || busy !== 1'b1) begin
            nMis++;
            $display("[TB] FAIL reset_restep got step=%0b pos=%0d busy=%0b want 1 1 1", step_pulse, pos, busy);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic l = 1'b0, r = 1'b0, e = 1'b0, rn;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) l = ~l;
            if ($urandom_range(0, 5) == 0) r = ~r;
            if ($urandom_range(0, 7) == 0) e = ~e;
            rn = ($urandom_range(0, 99) != 0);
            tick(l, r, e, rn);
            nVec++;
            if (int'(pos) != mPos || int'(step_pulse) != mStep || int'(step_dir) != mStepDir ||
                int'(select_pulse) != mSelect || int'(sel_pos) != mSelPos ||
                int'(clear_pulse) != mClear || int'(busy) != mBusy) begin
                nMis++;
                $display("[TB] FAIL random[%0d] got pos=%0d st=%0b dir=%0b sel=%0b sp=%0d clr=%0b busy=%0b want %0d %0d %0d %0d %0d %0d %0d",
                         i, pos, step_pulse, step_dir, select_pulse, sel_pos, clear_pulse, busy,
                         mPos, mStep, mStepDir, mSelect, mSelPos, mClear, mBusy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_wrap();
        test_auto_repeat();
        test_enter();
        test_chords();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

// File: doc/btn_nav_controller.md
Name: btn_nav_controller

Overview:
- Sequencer placed after the button debouncers. Its inputs are already-synchronized button levels for left, right and enter.
- Turns held buttons into navigation steps: one step on press, then an initial delay, then auto-repeat.
- Keeps a wrapping cursor position and reports short enter presses as selections.
- A long enter press produces a one-cycle clear pulse, which drives the debouncers' internal_reset and the downstream state.

Parameters:
- N_POS, 8, number of cursor positions; must be >= 2. Localparam POS_W = $clog2(N_POS).
- DELAY_CYC, 25_000_000, cycles from the first step to the first auto-repeat step; must be >= 1.
- REPEAT_CYC, 5_000_000, cycles between auto-repeat steps; must be >= 1.
- HOLD_CYC, 100_000_000, enter hold length that counts as a long press; must be >= 1.
- CNT_W, 27, hold/repeat counter width; must satisfy 2^CNT_W > max(DELAY_CYC, REPEAT_CYC, HOLD_CYC).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- left_lvl  in  1  debounced left level
- right_lvl  in  1  debounced right level
- enter_lvl  in  1  debounced enter level
- pos  out  POS_W  current cursor position
- step_pulse  out  1  one-cycle pulse on every cursor move
- step_dir  out  1  direction of the last move: 1 = right, 0 = left
- select_pulse  out  1  one-cycle pulse on a short enter press
- sel_pos  out  POS_W  value of pos captured with select_pulse
- clear_pulse  out  1  one-cycle pulse on a long enter press
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: synchronous. At a clk edge with rst_n low, all of the following load regardless of inputs:
  - state = IDLE, cnt = 0, pos = 0, sel_pos = 0, step_dir = 0.
  - step_pulse, select_pulse, clear_pulse = 0; busy = 0.
- All outputs are registered. Pulses are high for exactly one cycle and are deasserted at every edge that does not generate them.
- "Step": pos moves ±1 with wrap, step_pulse = 1, step_dir updated.
  - Right from N_POS-1 wraps to 0.
  - Left from 0 wraps to N_POS-1.
- Latency: a level sampled high at edge k produces its step at that same edge, so pos and step_pulse are visible in the cycle after edge k.
- Let A = the number of asserted inputs among left_lvl, right_lvl and enter_lvl.
- State IDLE:
  - A == 0: stay.
  - A >= 2: go to WAIT_REL with no action.
  - Only left or only right: step, latch the direction, cnt = 0, go to PRESS.
  - Only enter: cnt = 0, go to ENTER_HOLD.
- State PRESS:
  - Latched button low: go to IDLE.
  - Any other input high: go to WAIT_REL.
  - Otherwise, if cnt == DELAY_CYC-1: step, cnt = 0, go to REPEAT.
  - Otherwise cnt++.
- State REPEAT: same rules as PRESS, using REPEAT_CYC-1 and staying in REPEAT.
- State ENTER_HOLD:
  - left or right high: go to WAIT_REL; no select is generated.
  - enter low: select_pulse = 1, sel_pos = pos, go to IDLE.
  - cnt == HOLD_CYC-1: clear_pulse = 1, pos = 0, go to WAIT_REL.
  - Otherwise cnt++.
- State WAIT_REL: go to IDLE only when A == 0. No steps, selects or clears are generated here.
- Release at the same edge as a step match: the release wins and no step is generated.
- Reset mid-operation: a button still held after rst_n returns high is treated as a new press from IDLE. An immediate step is the required behaviour.
- N_POS that is not a power of two: pos never takes values >= N_POS.

Decomposition:
- Package nav_pkg holds:
  - the state enum: IDLE, PRESS, REPEAT, ENTER_HOLD, WAIT_REL;
  - direction constants DIR_LEFT = 0 and DIR_RIGHT = 1.
- One natural sub-module, nav_pos_counter:
  - a modulo-N_POS up/down counter with synchronous clear, step-enable and direction inputs;
  - contains the wrap logic.

Test Plan:
Common parameters: N_POS = 5, DELAY_CYC = 4, REPEAT_CYC = 2, HOLD_CYC = 6.
1. Reset, then right_lvl high for 1 cycle -> pos 0→1, step_pulse high exactly 1 cycle, step_dir = 1, busy returns to 0 after release.
2. From pos 0, left_lvl pulsed once -> pos = 4 (wrap). From pos 4, right pulsed once -> pos = 0.
3. right_lvl held for 10 samples starting at edge k -> steps at edges k, k+4, k+6, k+8; pos 0→4; no step after release.
4. At pos 2, enter held 3 samples -> select_pulse once on the release edge, sel_pos = 2, pos unchanged. Enter then held 8 samples -> clear_pulse at edge k+6, pos = 0, no select_pulse on release.
5. left_lvl and right_lvl rise together -> no step_pulse; busy stays 1 until both are low. Right pressed during ENTER_HOLD -> no select_pulse and no clear_pulse.
6. rst_n low for one edge during REPEAT with right held -> all outputs zero and pos = 0 after that edge. Next edge with rst_n high -> immediate step, pos = 1.
